// File: rtl/tmip_rx_pkg.sv
// tmip_rx_pkg -- shared types and helpers for the TMIP result receiver.
//   state_t     : receiver FSM states
//   size_e      : image_size encodings
//   WORD_W_DEF  : default serial word width
//   size_words(): frame size code -> number of words per frame
package tmip_rx_pkg;

  localparam int unsigned WORD_W_DEF = 20;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    SHIFT
  } state_t;

  typedef enum logic [1:0] {
    SIZE_4X4   = 2'd0,
    SIZE_8X8   = 2'd1,
    SIZE_16X16 = 2'd2,
    SIZE_RSVD  = 2'd3
  } size_e;

  // Words per frame; the reserved code maps to 0 and is never latched.
  function automatic int unsigned size_words(input logic [1:0] size);
    case (size)
      SIZE_4X4:   size_words = 16;
      SIZE_8X8:   size_words = 64;
      SIZE_16X16: size_words = 256;
      default:    size_words = 0;
    endcase
  endfunction

endpackage

// File: rtl/tmip_rx_deser.sv
// tmip_rx_deser -- MSB-first serial-to-parallel shifter with bit counter.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : drop any partial word and restart the bit counter
//   shift_en   : sample bit_in this cycle
//   bit_in     : serial data bit
//   word_next  : word formed by the stored bits plus bit_in
//   word_done  : bit_in is the last bit of a word this cycle
//   mid_word   : bit counter is non-zero (a word is partially received)
module tmip_rx_deser
  import tmip_rx_pkg::*;
#(
  parameter int unsigned WORD_W = WORD_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              shift_en,
  input  logic              bit_in,
  output logic [WORD_W-1:0] word_next,
  output logic              word_done,
  output logic              mid_word
);

  localparam int unsigned CNT_W = $clog2(WORD_W);

  // Only WORD_W-1 bits are stored; the final bit is taken straight from
  // bit_in so the completed word is available in the cycle it arrives.
  logic [WORD_W-2:0] sreg;
  logic [CNT_W-1:0]  bit_cnt;

  assign word_next = {sreg, bit_in};
  assign word_done = shift_en && (bit_cnt == CNT_W'(WORD_W - 1));
  assign mid_word  = (bit_cnt != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sreg    <= '0;
      bit_cnt <= '0;
    end else if (clr) begin
      sreg    <= '0;
      bit_cnt <= '0;
    end else if (shift_en) begin
      sreg    <= word_next[WORD_W-2:0];
      bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tmip_out_rx.sv
// tmip_out_rx -- receives the TMIP core's serial result stream and emits
// one parallel word per pixel with its raster index.
//   clk, rst_n  : clock, synchronous active-low reset
//   start       : arms reception of one frame (ignored while busy)
//   image_size  : 0 = 4x4, 1 = 8x8, 2 = 16x16, 3 = reserved
//   out_valid   : serial bit qualifier
//   out_value   : serial bit, MSB first
//   pix_valid   : one-cycle strobe, pix_data/pix_idx hold a new word
//   pix_data    : assembled word (holds last value otherwise)
//   pix_idx     : 0-based raster index of the word
//   frame_done  : one-cycle strobe together with the last word
//   busy        : frame in progress
//   err         : sticky [0] mid-word gap, [1] bit while idle, [2] bad size
module tmip_out_rx
  import tmip_rx_pkg::*;
#(
  parameter int unsigned WORD_W = WORD_W_DEF,
  parameter int unsigned IDX_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        image_size,
  input  logic              out_valid,
  input  logic              out_value,
  output logic              pix_valid,
  output logic [WORD_W-1:0] pix_data,
  output logic [IDX_W-1:0]  pix_idx,
  output logic              frame_done,
  output logic              busy,
  output logic [2:0]        err
);

  state_t             state;
  logic [IDX_W-1:0]   word_cnt;
  logic [IDX_W-1:0]   n_last;
  logic               receiving;
  logic               accept_start;
  logic               gap_abort;
  logic               deser_clr;
  logic [WORD_W-1:0]  word_next;
  logic               word_done;
  logic               mid_word;

  assign receiving    = (state == ARMED) || (state == SHIFT);
  assign accept_start = (state == IDLE) && start && (image_size != SIZE_RSVD);
  assign gap_abort    = (state == SHIFT) && !out_valid && mid_word;
  assign deser_clr    = accept_start || gap_abort;

  tmip_rx_deser #(
    .WORD_W(WORD_W)
  ) u_deser (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (deser_clr),
    .shift_en (receiving && out_valid),
    .bit_in   (out_value),
    .word_next(word_next),
    .word_done(word_done),
    .mid_word (mid_word)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      word_cnt   <= '0;
      n_last     <= '0;
      pix_valid  <= 1'b0;
      pix_data   <= '0;
      pix_idx    <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      err        <= '0;
    end else begin
      pix_valid  <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (image_size == SIZE_RSVD) begin
              err[2] <= 1'b1;
            end else begin
              // Store N-1 so a 256-word frame fits the IDX_W-bit counter.
              n_last   <= IDX_W'(size_words(image_size) - 1);
              word_cnt <= '0;
              err      <= '0;
              busy     <= 1'b1;
              state    <= ARMED;
            end
          end
          if (out_valid) err[1] <= 1'b1;
        end
        ARMED, SHIFT: begin
          if (out_valid) begin
            if (word_done) begin
              pix_valid <= 1'b1;
              pix_data  <= word_next;
              pix_idx   <= word_cnt;
              word_cnt  <= word_cnt + 1'b1;
              if (word_cnt == n_last) begin
                frame_done <= 1'b1;
                busy       <= 1'b0;
                state      <= IDLE;
              end else begin
                state <= ARMED;
              end
            end else begin
              state <= SHIFT;
            end
          end else if (gap_abort) begin
            err[0] <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/tmip_out_rx.md
TMIP_OUT_RX -- requirements
Module: tmip_out_rx

Interface
REQ-001 Parameter: WORD_W, 20, bit width of one serial result word.
REQ-002 Parameter: IDX_W, 8, width of the pixel index (covers 256 words).
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset; sampled on the clk rising edge.
REQ-005 start  input  1  one-cycle pulse that arms reception of one frame.
REQ-006 image_size  input  2  frame size at start: 0 = 4x4, 1 = 8x8, 2 = 16x16, 3 = reserved.
REQ-007 out_valid  input  1  serial-bit qualifier from the TMIP core.
REQ-008 out_value  input  1  serial result bit, MSB first.
REQ-009 pix_valid  output  1  one-cycle strobe marking a completed word.
REQ-010 pix_data  output  WORD_W  assembled word; valid while pix_valid = 1.
REQ-011 pix_idx  output  IDX_W  raster index of the word, 0-based.
REQ-012 frame_done  output  1  one-cycle strobe on the last word of a frame.
REQ-013 busy  output  1  high from an accepted start until the frame ends or aborts.
REQ-014 err  output  3  sticky flags: [0] mid-word gap, [1] out_valid while not armed, [2] reserved size.

Function
REQ-015 The FSM SHALL have 3 states: IDLE, ARMED and SHIFT.
REQ-016 In IDLE, start = 1 with image_size < 3 SHALL latch the expected word count N (16, 64 or 256), clear the bit counter and word counter, and enter ARMED.
REQ-017 In IDLE, start = 1 with image_size = 3 SHALL set err[2] and remain in IDLE.
REQ-018 start SHALL be ignored in ARMED and SHIFT; no restart mid-frame.
REQ-019 In ARMED or SHIFT, each cycle with out_valid = 1 SHALL shift out_value into the LSB of the shift register and increment the bit counter (0..WORD_W-1).
REQ-020 ARMED SHALL move to SHIFT on the first sampled bit of a word.
REQ-021 When bit WORD_W-1 is sampled, the bit counter SHALL wrap to 0, and on the next cycle pix_valid = 1, pix_data = the full word and pix_idx = the word count; the FSM then returns to ARMED.
REQ-022 Back-to-back words with out_valid held high SHALL be accepted with zero bubbles.
REQ-023 out_valid = 0 between words (bit counter = 0) SHALL be legal and SHALL hold state.
REQ-024 out_valid = 0 in SHIFT with bit counter != 0 SHALL set err[0], discard the partial word and return to IDLE; frame_done SHALL NOT assert.
REQ-025 After word N-1 completes, frame_done SHALL assert in the same cycle as that word's pix_valid, busy SHALL drop in that cycle, and the FSM SHALL be in IDLE.
REQ-026 out_valid = 1 in IDLE SHALL set err[1]; the bit is not shifted.
REQ-027 start in the same cycle as frame_done SHALL be accepted, because the FSM is already in IDLE.
REQ-028 err flags SHALL clear only on reset or on an accepted start.
REQ-029 All outputs SHALL be registered; pix_data SHALL hold its last value while pix_valid = 0.

Reset
REQ-030 While rst_n = 0 at a clk edge: FSM = IDLE; counters = 0; pix_valid, frame_done and busy = 0; pix_data = 0; pix_idx = 0; err = 0.
REQ-031 Reset asserted mid-frame SHALL abort the frame with no pix_valid or frame_done pulse on the following cycle.

Structure
REQ-032 Package tmip_rx_pkg SHALL hold the state enum, the WORD_W default, the size encodings, and a function mapping image_size to N.
REQ-033 The shift register and bit counter SHALL be one sub-module, tmip_rx_deser, which exposes a word_done strobe.

Verification
REQ-034 Reset, then start with size = 0, then 16 back-to-back words where word k = k*3 -> 16 pix_valid pulses with pix_idx 0..15 and matching data; frame_done with idx 15; err = 0.
REQ-035 Size = 1 with a 5-cycle out_valid gap between every word -> 64 words captured correctly; no err.
REQ-036 Word 0xFFFFF, then word 0x00001, in a size-0 frame -> pix_data = 0xFFFFF, then 0x00001, confirming MSB-first order.
REQ-037 out_valid drops after 7 bits of word 3 -> err[0] = 1, state IDLE, no frame_done; a later start clears err.
REQ-038 image_size = 3 at start -> err[2] = 1 and busy stays 0; out_valid pulses while idle -> err[1] = 1.
REQ-039 rst_n = 0 for 1 cycle mid-word in a size-2 frame -> all outputs 0 the next cycle; a new size-0 frame then completes normally.
